// File: rtl/led_shift_pkg.sv
// Shared types and constants for the LED row shifter.
package led_shift_pkg;

  localparam int BITS_DEF = 16;
  localparam int RDADDR_W = 7;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    LATCH,
    DONE
  } state_t;

  // Row-buffer address of word `word` inside the slice owned by chain `chain`.
  function automatic logic [RDADDR_W-1:0] word_addr(input int unsigned chain,
                                                   input int unsigned wpc,
                                                   input int unsigned word);
    int unsigned a;
    a = chain * wpc + word;
    return a[RDADDR_W-1:0];
  endfunction

endpackage

// File: rtl/led_row_shifter.sv
// Serialises one buffered LED row onto NUM_SHIFT parallel driver shift
// chains with a shared SCLK and LAT. One word per chain is fetched, shifted
// out MSB first, and the cycle repeats until each chain has sent its slice.
module led_row_shifter
  import led_shift_pkg::*;
#(
  parameter int NUM_SHIFT  = 4,
  parameter int WORDS      = 128,
  parameter int BITS       = BITS_DEF,
  parameter int RD_LAT     = 2,
  parameter int LAT_CYCLES = 2
) (
  input  logic                spiClk,
  input  logic                nReset,
  input  logic                cmdStart,
  output logic                cmdDone,
  output logic                busy,
  output logic [RDADDR_W-1:0] rdaddress,
  input  logic [BITS-1:0]     ledColBuf,
  output logic [NUM_SHIFT-1:0] SDOs,
  output logic                SCLK,
  output logic                LAT
);

  localparam int WPC       = WORDS / NUM_SHIFT;
  localparam int W_W       = (WPC > 1) ? $clog2(WPC) : 1;
  localparam int B_W       = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int C_W       = (NUM_SHIFT > 1) ? $clog2(NUM_SHIFT) : 1;
  localparam int FETCH_LEN = NUM_SHIFT + RD_LAT;
  localparam int CNT_MAX   = (FETCH_LEN > LAT_CYCLES) ? FETCH_LEN : LAT_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(FETCH_LEN - 1);
  localparam logic [CNT_W-1:0] LAT_LAST   = CNT_W'(LAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CHAINS     = CNT_W'(NUM_SHIFT);
  localparam logic [W_W-1:0]   W_LAST     = W_W'(WPC - 1);
  localparam logic [B_W-1:0]   B_TOP      = B_W'(BITS - 1);

  if ((WORDS % NUM_SHIFT) != 0 || WORDS > (1 << RDADDR_W) ||
      RD_LAT < 1 || LAT_CYCLES < 1) begin : g_bad_params
    $error("led_row_shifter: illegal parameter combination");
  end

  state_t                           r_state, w_state_nxt;
  logic [W_W-1:0]                   r_w, w_w_nxt;
  logic [CNT_W-1:0]                 r_cnt, w_cnt_nxt;
  logic [B_W-1:0]                   r_bit, w_bit_nxt;
  logic                             r_phase, w_phase_nxt;
  logic [NUM_SHIFT-1:0][BITS-1:0]   r_shreg, w_shreg_nxt;
  logic                             r_rd_v, w_rd_v_nxt;
  logic [C_W-1:0]                   r_rd_c, w_rd_c_nxt;
  logic [RD_LAT-1:0]                r_pipe_v;
  logic [RD_LAT-1:0][C_W-1:0]       r_pipe_c;
  logic                             r_busy, w_busy_nxt;
  logic                             r_done, w_done_nxt;
  logic                             r_sclk, w_sclk_nxt;
  logic                             r_lat, w_lat_nxt;
  logic [NUM_SHIFT-1:0]             r_sdo, w_sdo_nxt;
  logic [RDADDR_W-1:0]              r_rdaddr, w_rdaddr_nxt;

  // Next-state, datapath and registered-output values.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_w_nxt     = r_w;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_phase_nxt = r_phase;
    w_shreg_nxt = r_shreg;

    // The word addressed RD_LAT cycles ago lands in its chain's register.
    if (r_pipe_v[RD_LAT-1]) w_shreg_nxt[r_pipe_c[RD_LAT-1]] = ledColBuf;

    case (r_state)
      IDLE: begin
        if (cmdStart) begin
          w_state_nxt = FETCH;
          w_w_nxt     = '0;
          w_cnt_nxt   = '0;
        end
      end
      FETCH: begin
        if (r_cnt == FETCH_LAST) begin
          w_state_nxt = SHIFT;
          w_phase_nxt = 1'b0;
          w_bit_nxt   = B_TOP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (!r_phase) begin
          w_phase_nxt = 1'b1;
        end else begin
          w_phase_nxt = 1'b0;
          for (int c = 0; c < NUM_SHIFT; c++) w_shreg_nxt[c] = r_shreg[c] << 1;
          if (r_bit == '0) begin
            w_cnt_nxt = '0;
            if (r_w == W_LAST) begin
              w_state_nxt = LATCH;
            end else begin
              w_w_nxt     = r_w + 1'b1;
              w_state_nxt = FETCH;
            end
          end else begin
            w_bit_nxt = r_bit - 1'b1;
          end
        end
      end
      LATCH: begin
        if (r_cnt == LAT_LAST) w_state_nxt = DONE;
        else                   w_cnt_nxt   = r_cnt + 1'b1;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    // Outputs are registered, so they are derived from the upcoming state.
    w_busy_nxt = (w_state_nxt != IDLE);
    w_done_nxt = (w_state_nxt == DONE);
    w_lat_nxt  = (w_state_nxt == LATCH);
    w_sclk_nxt = (w_state_nxt == SHIFT) && w_phase_nxt;
    w_sdo_nxt  = '0;
    if (w_state_nxt == SHIFT) begin
      for (int c = 0; c < NUM_SHIFT; c++) w_sdo_nxt[c] = w_shreg_nxt[c][BITS-1];
    end

    w_rd_v_nxt   = 1'b0;
    w_rd_c_nxt   = r_rd_c;
    w_rdaddr_nxt = r_rdaddr;
    if (w_state_nxt == FETCH && w_cnt_nxt < CHAINS) begin
      w_rd_v_nxt   = 1'b1;
      w_rd_c_nxt   = C_W'(w_cnt_nxt);
      w_rdaddr_nxt = word_addr(int'(w_cnt_nxt), WPC, int'(w_w_nxt));
    end
  end

  // Control state, capture pipe and output registers with synchronous reset.
  always_ff @(posedge spiClk) begin
    // NOTE: nonblocking assignments so every register samples pre-edge values.
    if (!nReset) begin
      r_state  <= IDLE;
      r_w      <= '0;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_phase  <= 1'b0;
      r_rd_v   <= 1'b0;
      r_rd_c   <= '0;
      r_pipe_v <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sclk   <= 1'b0;
      r_lat    <= 1'b0;
      r_sdo    <= '0;
      r_rdaddr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_w      <= w_w_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bit    <= w_bit_nxt;
      r_phase  <= w_phase_nxt;
      r_rd_v   <= w_rd_v_nxt;
      r_rd_c   <= w_rd_c_nxt;
      r_pipe_v[0] <= r_rd_v;
      for (int i = 1; i < RD_LAT; i++) r_pipe_v[i] <= r_pipe_v[i-1];
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_sclk   <= w_sclk_nxt;
      r_lat    <= w_lat_nxt;
      r_sdo    <= w_sdo_nxt;
      r_rdaddr <= w_rdaddr_nxt;
    end
  end

  // Shift data and chain tags of the capture pipe.
  always_ff @(posedge spiClk) begin
    // NOTE: data-only registers are left unreset; each word is loaded before
    // it is shifted out, and the valid bits above gate every capture.
    r_shreg     <= w_shreg_nxt;
    r_pipe_c[0] <= r_rd_c;
    for (int i = 1; i < RD_LAT; i++) r_pipe_c[i] <= r_pipe_c[i-1];
  end

  assign cmdDone   = r_done;
  assign busy      = r_busy;
  assign rdaddress = r_rdaddr;
  assign SDOs      = r_sdo;
  assign SCLK      = r_sclk;
  assign LAT       = r_lat;

endmodule
